// File: rtl/gate_sweep_pkg.sv
// Shared encodings for the gate sweep checker.
//   mode_e  : expected-function select driven on the checker's mode port
//   state_e : sweep FSM state encoding
package gate_sweep_pkg;

    localparam int unsigned MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_AND  = 3'd0,
        MODE_NAND = 3'd1,
        MODE_OR   = 3'd2,
        MODE_NOR  = 3'd3,
        MODE_XOR  = 3'd4,
        MODE_XNOR = 3'd5,
        MODE_BUF  = 3'd6,
        MODE_NOT  = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/gate_sweep_checker_ref_model.sv
// gate_ref_model: combinational expected output of an N-input gate.
//   mode       : selected gate function
//   vec        : stimulus vector applied to the gate
//   expected_c : ideal gate output for (mode, vec); BUF/NOT use bit 0 only
module gate_ref_model
    import gate_sweep_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  mode_e          mode,
    input  logic [N-1:0]   vec,
    output logic           expected_c
);

    always_comb begin
        expected_c = 1'b0;
        case (mode)
            MODE_AND:  expected_c = &vec;
            MODE_NAND: expected_c = ~&vec;
            MODE_OR:   expected_c = |vec;
            MODE_NOR:  expected_c = ~|vec;
            MODE_XOR:  expected_c = ^vec;
            MODE_XNOR: expected_c = ~^vec;
            MODE_BUF:  expected_c = vec[0];
            MODE_NOT:  expected_c = ~vec[0];
            default:   expected_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: exhaustively sweeps all 2^N input vectors of a gate
// under test, holding each for SETTLE+1 cycles and checking dut_f in the
// final cycle against the selected ideal gate function.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begin a sweep (accepted only in IDLE)
//   abort       : cancel a running sweep
//   mode        : expected gate function, latched at start
//   dut_in      : registered stimulus vector
//   dut_f       : gate-under-test output
//   busy        : sweep in progress (through the DONE cycle)
//   done        : one-cycle completion pulse
//   pass        : last completed sweep had no mismatches
//   err_count   : mismatch count of the current or last sweep
//   first_fail  : vector of the first mismatch
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int unsigned N      = 2,
    parameter int unsigned SETTLE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [MODE_W-1:0]  mode,
    output logic [N-1:0]       dut_in,
    input  logic               dut_f,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [N:0]         err_count,
    output logic [N-1:0]       first_fail
);

    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned ERR_W = N + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [N-1:0]     VEC_MAX  = '1;

    state_e           state;
    mode_e            mode_q;
    logic [CNT_W-1:0] settle_cnt;
    logic             expected_c;
    logic             mismatch_c;

    gate_ref_model #(.N(N)) u_ref (
        .mode       (mode_q),
        .vec        (dut_in),
        .expected_c (expected_c)
    );

    // Case equality so that X/Z on dut_f is treated as a mismatch.
    assign mismatch_c = !(dut_f === expected_c);

    // Sweep FSM with its counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_AND;
            settle_cnt <= '0;
            dut_in     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q     <= mode_e'(mode);
                        dut_in     <= '0;
                        err_count  <= '0;
                        first_fail <= '0;
                        pass       <= 1'b0;
                        settle_cnt <= CNT_LOAD;
                        busy       <= 1'b1;
                        state      <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (abort) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        pass       <= 1'b0;
                        dut_in     <= '0;
                        settle_cnt <= '0;
                    end else if (settle_cnt == '0) begin
                        state <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end

                ST_CHECK: begin
                    // Abort wins over the mismatch bookkeeping of this cycle.
                    if (abort) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        pass       <= 1'b0;
                        dut_in     <= '0;
                        settle_cnt <= '0;
                    end else begin
                        if (mismatch_c) begin
                            err_count <= err_count + ERR_W'(1);
                            if (err_count == '0) begin
                                first_fail <= dut_in;
                            end
                        end
                        if (dut_in == VEC_MAX) begin
                            // pass reflects this final check as well.
                            state <= ST_DONE;
                            done  <= 1'b1;
                            pass  <= (err_count == '0) && !mismatch_c;
                        end else begin
                            dut_in     <= dut_in + N'(1);
                            settle_cnt <= CNT_LOAD;
                            state      <= ST_SETTLE;
                        end
                    end
                end

                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Self-checking bench for gate_sweep_checker: three instances with different
// (N, SETTLE), each fed by a behavioural gate model with optional faults.
module tb_gate_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] start, abort, dut_f;
    logic [2:0] mode [3];

    wire [1:0] din0, ff0;
    wire [2:0] din1, ff1, err0;
    wire [3:0] din2, ff2, err1;
    wire [4:0] err2;
    wire [2:0] busy, done, pass;

    logic [7:0] din [3];
    logic [7:0] ffv [3];
    logic [8:0] errc [3];

    // Model configuration per instance (fault kinds: 0 none, 1 stuck0,
    // 2 invert on fvec, 3 X on fvec, 4 stuck1).
    logic [2:0] mode_tb [3];
    int         kind [3];
    int         fvec [3];

    int checks = 0;
    int errors = 0;

    gate_sweep_checker #(.N(2), .SETTLE(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .mode(mode[0]),
        .dut_in(din0), .dut_f(dut_f[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(err0), .first_fail(ff0));
    gate_sweep_checker #(.N(3), .SETTLE(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .mode(mode[1]),
        .dut_in(din1), .dut_f(dut_f[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(err1), .first_fail(ff1));
    gate_sweep_checker #(.N(4), .SETTLE(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]), .mode(mode[2]),
        .dut_in(din2), .dut_f(dut_f[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .err_count(err2), .first_fail(ff2));

    always_comb begin
        din[0] = 8'(din0); din[1] = 8'(din1); din[2] = 8'(din2);
        ffv[0] = 8'(ff0);  ffv[1] = 8'(ff1);  ffv[2] = 8'(ff2);
        errc[0] = 9'(err0); errc[1] = 9'(err1); errc[2] = 9'(err2);
    end

    function automatic int n_of(input int id);
        return (id == 0) ? 2 : (id == 1) ? 3 : 4;
    endfunction

    function automatic int s_of(input int id);
        return (id == 0) ? 4 : (id == 1) ? 2 : 1;
    endfunction

    // Ideal gate value from the count of ones among the N inputs.
    function automatic bit gate_fn(input logic [2:0] m, input logic [7:0] v, input int n);
        int ones = 0;
        for (int i = 0; i < n; i++) ones += int'(v[i]);
        case (m)
            3'd0: return ones == n;
            3'd1: return ones != n;
            3'd2: return ones > 0;
            3'd3: return ones == 0;
            3'd4: return (ones % 2) == 1;
            3'd5: return (ones % 2) == 0;
            3'd6: return v[0];
            default: return !v[0];
        endcase
    endfunction

    function automatic logic model_f(input logic [2:0] m, input int k, input int fv,
                                     input logic [7:0] v, input int n);
        bit g = gate_fn(m, v, n);
        case (k)
            1: return 1'b0;
            2: return (int'(v) == fv) ? !g : g;
            3: return (int'(v) == fv) ? 1'bx : g;
            4: return 1'b1;
            default: return g;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++)
            dut_f[i] = model_f(mode_tb[i], kind[i], fvec[i], din[i], n_of(i));
    end

    // Full sweep on one instance; poke re-pulses start at that cycle while busy.
    task automatic run_sweep(input int id, input logic [2:0] m, input int k, input int fv,
                             input bit scramble, input int poke);
        int n = n_of(id);
        int s = s_of(id);
        int nv = 1 << n;
        int lat_exp = nv * (s + 1) + 1;
        int e_err = 0;
        int e_ff = 0;
        int lat = 0;
        bit bad = 0;
        bit busy_at_done;
        for (int v = 0; v < nv; v++) begin
            bit g = gate_fn(m, 8'(v), n);
            bit mm;
            case (k)
                1: mm = g;
                2, 3: mm = (v == fv);
                4: mm = !g;
                default: mm = 1'b0;
            endcase
            if (mm) begin
                if (e_err == 0) e_ff = v;
                e_err++;
            end
        end
        mode_tb[id] = m; kind[id] = k; fvec[id] = fv;
        mode[id] = m;
        start[id] = 1'b1;
        @(posedge clk); #1;
        start[id] = 1'b0;
        for (int e = 1; e <= 200; e++) begin
            if (done[id] === 1'b1) begin lat = e; break; end
            if (din[id] !== 8'((e - 1) / (s + 1))) bad = 1;
            if (busy[id] !== 1'b1) bad = 1;
            if (scramble) mode[id] = 3'($urandom);
            start[id] = (e == poke);
            @(posedge clk); #1;
        end
        start[id] = 1'b0;
        busy_at_done = busy[id];

        checks++;
        if (lat != lat_exp) begin
            errors++; $display("FAIL latency id%0d: got %0d want %0d", id, lat, lat_exp);
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL vector_sequence id%0d: dut_in/busy deviated during sweep", id);
        end
        checks++;
        if (errc[id] !== 9'(e_err)) begin
            errors++; $display("FAIL err_count id%0d: got %0d want %0d", id, errc[id], e_err);
        end
        checks++;
        if (ffv[id] !== 8'(e_ff)) begin
            errors++; $display("FAIL first_fail id%0d: got %0h want %0h", id, ffv[id], e_ff);
        end
        checks++;
        if (pass[id] !== (e_err == 0) || busy_at_done !== 1'b1) begin
            errors++; $display("FAIL pass_at_done id%0d: pass %b busy %b want pass %b busy 1",
                               id, pass[id], busy_at_done, e_err == 0);
        end
        @(posedge clk); #1;
        checks++;
        if (done[id] !== 1'b0 || busy[id] !== 1'b0 || pass[id] !== (e_err == 0)
            || errc[id] !== 9'(e_err)) begin
            errors++; $display("FAIL after_done id%0d: done %b busy %b pass %b err %0d want 0 0 %b %0d",
                               id, done[id], busy[id], pass[id], errc[id], e_err == 0, e_err);
        end
    endtask

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (din[i] !== 8'd0 || busy[i] !== 1'b0 || done[i] !== 1'b0 || pass[i] !== 1'b0
                || errc[i] !== 9'd0 || ffv[i] !== 8'd0) begin
                errors++;
                $display("FAIL %s id%0d: din %0h busy %b done %b pass %b err %0d ff %0h want all 0",
                         tag, i, din[i], busy[i], done[i], pass[i], errc[i], ffv[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = '0; abort = '0;
        for (int i = 0; i < 3; i++) begin
            mode[i] = '0; mode_tb[i] = '0; kind[i] = 0; fvec[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_nand_ideal();
        run_sweep(0, 3'd1, 0, 0, 0, 0);
    endtask

    task automatic test_nor_stuck0();
        run_sweep(1, 3'd3, 1, 0, 0, 0);
    endtask

    task automatic test_xor_invert();
        run_sweep(2, 3'd4, 2, 6, 0, 0);
    endtask

    task automatic test_abort();
        bit saw_done = 0;
        // Abort in IDLE must not disturb the last (passing) result.
        abort[0] = 1'b1;
        @(posedge clk); #1;
        abort[0] = 1'b0;
        checks++;
        if (pass[0] !== 1'b1 || busy[0] !== 1'b0 || errc[0] !== 9'd0) begin
            errors++; $display("FAIL idle_abort: pass %b busy %b err %0d want 1 0 0",
                               pass[0], busy[0], errc[0]);
        end
        // NOR stuck at 0 fails only vector 0, which is checked before the abort.
        mode_tb[1] = 3'd3; kind[1] = 1; fvec[1] = 0; mode[1] = 3'd3;
        start[1] = 1'b1;
        @(posedge clk); #1;
        start[1] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        abort[1] = 1'b1;
        @(posedge clk); #1;
        abort[1] = 1'b0;
        checks++;
        if (busy[1] !== 1'b0 || pass[1] !== 1'b0 || din[1] !== 8'd0 || errc[1] !== 9'd1
            || done[1] !== 1'b0) begin
            errors++; $display("FAIL abort_state: busy %b pass %b din %0h err %0d done %b want 0 0 0 1 0",
                               busy[1], pass[1], din[1], errc[1], done[1]);
        end
        for (int c = 0; c < 40; c++) begin
            if (done[1] !== 1'b0 || busy[1] !== 1'b0) saw_done = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (saw_done) begin
            errors++; $display("FAIL abort_no_done: done/busy seen after abort, want none");
        end
        run_sweep(1, 3'd2, 0, 0, 0, 0);
    endtask

    task automatic test_x_input();
        run_sweep(0, 3'd0, 3, 3, 0, 0);
    endtask

    task automatic test_reset_mid();
        bit woke = 0;
        mode_tb[2] = 3'd5; kind[2] = 2; fvec[2] = 1; mode[2] = 3'd5;
        start[2] = 1'b1;
        @(posedge clk); #1;
        start[2] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start[2] = 1'b1;
        @(posedge clk); #1;
        start[2] = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_mid");
        start[2] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start[2] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (busy[2] !== 1'b0 || done[2] !== 1'b0) woke = 1;
        end
        checks++;
        if (woke) begin
            errors++; $display("FAIL reset_discard: busy/done seen after reset without new start");
        end
        run_sweep(2, 3'd6, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_sweep(2, 3'd5, 0, 0, 0, 7);
        run_sweep(2, 3'd7, 4, 0, 1, 0);
        run_sweep(1, 3'd0, 2, 7, 1, 5);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int id = int'($urandom_range(0, 2));
            int kpick = int'($urandom_range(0, 3));
            int k = (kpick == 3) ? 4 : kpick;
            int fv = int'($urandom_range(0, (1 << n_of(id)) - 1));
            int poke = int'($urandom_range(2, 15));
            run_sweep(id, 3'($urandom), k, fv, 1, poke);
        end
    endtask

    initial begin
        test_reset();
        test_nand_ideal();
        test_nor_stuck0();
        test_xor_invert();
        test_abort();
        test_x_input();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_sweep_checker.md
GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

Interface
REQ-001 The block SHALL have parameter N, default 2, giving the DUT gate input count (legal 1..8).
REQ-002 The block SHALL have parameter SETTLE, default 4, giving the settle cycles per vector before sampling (legal >= 1).
REQ-003 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port start, input, 1, begins a sweep when sampled high in IDLE.
REQ-006 Port abort, input, 1, cancels a running sweep.
REQ-007 Port mode, input, 3, expected-function select: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 BUF(bit0), 7 NOT(bit0).
REQ-008 Port dut_in, output, N, the registered stimulus vector driven to the gate under test.
REQ-009 Port dut_f, input, 1, the gate-under-test output.
REQ-010 Port busy, output, 1, high from the cycle after start is accepted until DONE is left.
REQ-011 Port done, output, 1, one-cycle pulse at sweep completion.
REQ-012 Port pass, output, 1, high when the last completed sweep had zero mismatches.
REQ-013 Port err_count, output, N+1, mismatch count of the current or last sweep.
REQ-014 Port first_fail, output, N, vector of the first mismatch in the current or last sweep.

Function
REQ-015 The FSM SHALL have states IDLE, SETTLE, CHECK and DONE.
REQ-016 In IDLE with start=1, the block SHALL latch mode, load dut_in=0, clear err_count, first_fail and pass, load the settle counter with SETTLE-1, and enter SETTLE.
REQ-017 In SETTLE, the settle counter SHALL decrement once per cycle, and the block SHALL enter CHECK in the cycle after the counter reads 0.
REQ-018 Each vector SHALL therefore be held on dut_in for exactly SETTLE+1 cycles, with dut_f sampled in the CHECK cycle.
REQ-019 In CHECK, the block SHALL compare dut_f with the expected value of the latched mode applied as a reduction over all N bits of dut_in.
REQ-020 An X or Z on dut_f SHALL count as a mismatch.
REQ-021 On a mismatch, err_count SHALL increment, and first_fail SHALL capture dut_in only if err_count was 0.
REQ-022 In CHECK, if dut_in equals 2^N-1 the block SHALL enter DONE; otherwise dut_in SHALL increment by 1, the settle counter SHALL reload, and the block SHALL enter SETTLE.
REQ-023 DONE SHALL last one cycle with done=1 and pass set to (err_count==0), then return to IDLE.
REQ-024 pass, err_count and first_fail SHALL hold their values in IDLE until the next accepted start.
REQ-025 A start asserted while busy=1 SHALL be ignored.
REQ-026 Changes on mode while busy=1 SHALL have no effect on the running sweep.
REQ-027 abort=1 in SETTLE or CHECK SHALL return the block to IDLE next cycle with pass=0, done not pulsed, dut_in=0, and err_count held.
REQ-028 abort SHALL take priority over a CHECK-cycle mismatch update.
REQ-029 abort=1 in IDLE SHALL be a no-op.
REQ-030 The total cycles from start acceptance to the done pulse SHALL be 2^N*(SETTLE+1)+1.

Reset
REQ-031 With rst_n=0, the block SHALL asynchronously force state=IDLE, dut_in=0, busy=0, done=0, pass=0, err_count=0, first_fail=0 and settle counter=0.
REQ-032 Reset asserted mid-sweep SHALL discard the sweep without a done pulse.
REQ-033 After reset release, the first start SHALL be accepted on the first rising edge where rst_n=1 and start=1.

Structure
REQ-034 Package gate_sweep_pkg SHALL hold the mode encodings and the FSM state encoding.
REQ-035 Sub-module gate_ref_model SHALL be the combinational expected-value function taking (mode, vector) and returning the expected output bit, parameterised by N.
REQ-036 Counters and the FSM SHALL reside in gate_sweep_checker.

Verification
REQ-037 The bench SHALL cover: N=2, SETTLE=4, mode=1, ideal NAND on dut_f -> done after 21 cycles, pass=1, err_count=0.
REQ-038 The bench SHALL cover: N=3, mode=3, NOR model with output stuck at 0 -> err_count=1, first_fail=3'b000, pass=0.
REQ-039 The bench SHALL cover: N=4, mode=4, XOR model inverted on vector 4'b0110 only -> err_count=1, first_fail=4'b0110.
REQ-040 The bench SHALL cover: abort 10 cycles after start -> busy=0 next cycle, no done pulse, pass=0; a new start then runs a full sweep to pass=1.
REQ-041 The bench SHALL cover: rst_n pulsed low mid-sweep, then start pulsed again while busy -> all outputs at reset values, and the repeated start is ignored.
REQ-042 The bench SHALL cover: dut_f driven X for one vector with N=2, mode=0 -> err_count=1, pass=0.
